// File: rtl/prog_harness_seq.sv
// prog_harness_seq: loads an operand block into data memory, starts the processor, waits for halt, drains a result region.
// Ports: CLK/reset (sync, active-high); go starts a run from IDLE/DONE; in_* is the operand stream (valid/ready);
// mem_* is the data memory master port, valid while busy_mem; proc_start/proc_halt face the processor;
// out_* is the result stream (valid/ready); done, timeout_err and cycle_count report the last run.
module prog_harness_seq #(
  parameter int AW = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN = 64,
  parameter int RES_BASE = 64,
  parameter int RES_LEN = 32,
  parameter int START_CYCLES = 2,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          go,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data,
  output logic          busy_mem,
  output logic          proc_start,
  input  logic          proc_halt,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          done,
  output logic          timeout_err,
  output logic [15:0]   cycle_count
);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [15:0] idx, idx_n, cnt_n;
  logic err_n;
  // idx is the byte index in LOAD/DRAIN and doubles as the start-pulse counter in START
  wire last_ld = idx == 16'(LOAD_LEN - 1);
  wire last_st = idx == 16'(START_CYCLES - 1);
  wire last_rs = idx == 16'(RES_LEN - 1);
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      cycle_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cycle_count <= cnt_n;
      timeout_err <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cycle_count;
    err_n = timeout_err;
    case (state)
      IDLE, DONE: if (go) begin
        state_n = LOAD;
        idx_n = '0;
        cnt_n = '0;
        err_n = 1'b0;
      end
      LOAD: if (in_valid) begin
        state_n = last_ld ? START : LOAD;
        idx_n = last_ld ? '0 : idx + 16'd1;
      end
      START: begin
        state_n = last_st ? RUN : START;
        idx_n = last_st ? '0 : idx + 16'd1;
      end
      RUN: if (proc_halt) state_n = DRAIN;
      else begin
        cnt_n = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
        // the increment that brings the count to TIMEOUT aborts the run
        if (cycle_count == TIMEOUT - 16'd1) begin
          state_n = DONE;
          err_n = 1'b1;
        end
      end
      DRAIN: if (out_ready) begin
        state_n = last_rs ? DONE : DRAIN;
        idx_n = last_rs ? '0 : idx + 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign in_ready = state == LOAD;
  assign out_valid = state == DRAIN;
  assign busy_mem = in_ready || out_valid;
  assign proc_start = state == START;
  assign done = state == DONE;
  assign mem_addr = in_ready ? AW'(LOAD_BASE) + idx[AW-1:0] : out_valid ? AW'(RES_BASE) + idx[AW-1:0] : '0;
  assign mem_wr_en = in_ready && in_valid;
  assign mem_wr_data = in_ready ? in_data : '0;
  assign out_data = out_valid ? mem_rd_data : '0;
endmodule

// File: tb/tb_prog_harness_seq.sv
// tb_prog_harness_seq: randomized run-level checks of prog_harness_seq against a memory-image scoreboard.
module tb_prog_harness_seq;
  logic CLK = 0, reset = 1, fill = 1, go = 0, in_valid = 0, out_ready = 0, proc_halt = 0;
  logic [7:0] in_data = 0;
  int s = 0;
  logic [1:0] go_v, in_ready, mem_wr_en, busy_mem, proc_start, out_valid, done, timeout_err;
  logic [7:0] mem_addr [2], mem_wr_data [2], mem_rd_data [2], out_data [2];
  logic [15:0] cycle_count [2];
  logic [7:0] mem [2][256], img [2][256], exp_mem [2][256];
  int lb [2] = '{0, 3}, ll [2] = '{64, 8}, rb [2] = '{64, 250}, rl [2] = '{32, 10};
  int sc [2] = '{2, 3}, tmo [2] = '{65535, 20};
  int n_vec = 0, n_err = 0;
  int wr_n, st_n, st_rise, ov_n, beat;
  logic st_prev, acc;
  always #5 CLK = ~CLK;
  assign go_v[0] = go && s == 0;
  assign go_v[1] = go && s == 1;
  prog_harness_seq u0 (
    .CLK(CLK), .reset(reset), .go(go_v[0]), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[0]),
    .mem_addr(mem_addr[0]), .mem_wr_en(mem_wr_en[0]), .mem_wr_data(mem_wr_data[0]), .mem_rd_data(mem_rd_data[0]),
    .busy_mem(busy_mem[0]), .proc_start(proc_start[0]), .proc_halt(proc_halt), .out_valid(out_valid[0]),
    .out_data(out_data[0]), .out_ready(out_ready), .done(done[0]), .timeout_err(timeout_err[0]),
    .cycle_count(cycle_count[0])
  );
  prog_harness_seq #(.LOAD_BASE(3), .LOAD_LEN(8), .RES_BASE(250), .RES_LEN(10), .START_CYCLES(3), .TIMEOUT(16'd20)) u1 (
    .CLK(CLK), .reset(reset), .go(go_v[1]), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[1]),
    .mem_addr(mem_addr[1]), .mem_wr_en(mem_wr_en[1]), .mem_wr_data(mem_wr_data[1]), .mem_rd_data(mem_rd_data[1]),
    .busy_mem(busy_mem[1]), .proc_start(proc_start[1]), .proc_halt(proc_halt), .out_valid(out_valid[1]),
    .out_data(out_data[1]), .out_ready(out_ready), .done(done[1]), .timeout_err(timeout_err[1]),
    .cycle_count(cycle_count[1])
  );
  always @(posedge CLK) begin
    if (fill) mem <= img;
    else for (int i = 0; i < 2; i++) if (mem_wr_en[i]) mem[i][mem_addr[i]] <= mem_wr_data[i];
  end
  assign mem_rd_data[0] = mem[0][mem_addr[0]];
  assign mem_rd_data[1] = mem[1][mem_addr[1]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // observe one cycle of the selected instance mid-cycle, then advance to just after the next edge
  task automatic sample();
    @(negedge CLK);
    acc = in_valid && in_ready[s];
    if (mem_wr_en[s]) begin
      chk("wr_addr", 32'(mem_addr[s]), 32'((lb[s] + wr_n) % 256));
      chk("wr_data", 32'(mem_wr_data[s]), 32'(in_data));
      chk("wr_bubble", 32'(in_valid), 1);
      wr_n++;
    end
    if (proc_start[s]) begin
      st_n++;
      if (!st_prev) st_rise++;
      chk("busy_start", 32'(busy_mem[s]), 0);
    end
    st_prev = proc_start[s];
    if (out_valid[s]) begin
      ov_n++;
      chk("rd_addr", 32'(mem_addr[s]), 32'((rb[s] + beat) % 256));
      chk("out_data", 32'(out_data[s]), 32'(exp_mem[s][(rb[s] + beat) % 256]));
      chk("busy_drain", 32'(busy_mem[s]), 1);
      if (out_ready) beat++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, {in_ready[s], mem_wr_en[s], busy_mem[s], proc_start[s], out_valid[s], done[s], timeout_err[s]}, 0);
    chk({tag, "_addr"}, 32'(mem_addr[s]), 0);
    chk({tag, "_wdata"}, 32'(mem_wr_data[s]), 0);
    chk({tag, "_odata"}, 32'(out_data[s]), 0);
    chk({tag, "_cnt"}, 32'(cycle_count[s]), 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    go = 0;
    out_ready = 0;
    proc_halt = 0;
    sample();
    reset = 0;
    check_idle(tag);
  endtask

  // abort: 0 none, 1 reset during RUN, 2 reset during DRAIN; halt_at < 0 runs into the timeout
  task automatic run(input int sel, input int bub, input int stall, input int halt_at, input int abort);
    int k, guard, stalled;
    logic [7:0] d;
    s = sel;
    wr_n = 0; st_n = 0; st_rise = 0; ov_n = 0; beat = 0; st_prev = 0; stalled = 0;
    go = 1;
    sample();
    go = 0;
    chk("go_clr_err", 32'(timeout_err[s]), 0);
    chk("go_clr_cnt", 32'(cycle_count[s]), 0);
    chk("go_load", 32'(in_ready[s]), 1);
    k = 0;
    guard = 0;
    while (k < ll[s] && guard < 1000) begin
      in_valid = bub ? (guard % 2 == 0) : 1'b1;
      in_data = 8'($urandom);
      d = in_data;
      sample();
      if (acc) begin
        exp_mem[s][(lb[s] + k) % 256] = d;
        k++;
      end
      guard++;
    end
    in_valid = 0;
    chk("ld_bytes", k, ll[s]);
    chk("ld_writes", wr_n, ll[s]);
    chk("ld_cycles", guard, bub ? 2 * ll[s] - 1 : ll[s]);
    chk("start_hi", 32'(proc_start[s]), 1);
    go = 1;
    guard = 0;
    while (proc_start[s] && guard < 100) begin
      sample();
      guard++;
    end
    chk("start_len", st_n, sc[s]);
    chk("start_rise", st_rise, 1);
    chk("run_ready", {in_ready[s], busy_mem[s], mem_wr_en[s]}, 0);
    if (abort == 1) begin
      repeat (5) sample();
      do_reset("rst_run");
      return;
    end
    if (halt_at >= 0) begin
      for (int h = 0; h < halt_at; h++) begin
        sample();
        chk("run_go_ign", {in_ready[s], busy_mem[s], done[s]}, 0);
      end
      go = 0;
      proc_halt = 1;
      sample();
      proc_halt = 0;
      chk("halt_cnt", 32'(cycle_count[s]), halt_at);
      chk("drain_vld", 32'(out_valid[s]), 1);
      guard = 0;
      while (!done[s] && guard < 300) begin
        out_ready = (stall >= 0 && beat == stall && stalled < 3) ? 1'b0 : 1'b1;
        if (!out_ready) stalled++;
        if (abort == 2 && beat == 3) break;
        sample();
        guard++;
      end
      out_ready = 0;
      if (abort == 2) begin
        do_reset("rst_drain");
        return;
      end
      chk("beats", beat, rl[s]);
      chk("vld_cycles", ov_n, rl[s] + (stall >= 0 ? 3 : 0));
      chk("done", {done[s], out_valid[s], in_ready[s], timeout_err[s]}, 4'b1000);
      chk("cnt_frozen", 32'(cycle_count[s]), halt_at);
    end else begin
      go = 0;
      guard = 0;
      while (!done[s] && guard < 100) begin
        sample();
        guard++;
      end
      chk("to_cycles", guard, tmo[s]);
      chk("to_err", 32'(timeout_err[s]), 1);
      chk("to_cnt", 32'(cycle_count[s]), tmo[s]);
      chk("to_no_out", ov_n, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) img[i][a] = 8'($urandom);
    exp_mem = img;
    repeat (3) @(posedge CLK);
    #1;
    reset = 0;
    fill = 0;
    s = 0;
    check_idle("rst0");
    s = 1;
    check_idle("rst1");
    run(0, 0, -1, 100, 0);
    run(0, 1, 5, 37, 0);
    run(1, 0, -1, -1, 0);
    run(1, 1, 3, 0, 0);
    run(0, 0, -1, 10, 1);
    run(0, 0, -1, $urandom_range(1, 50), 2);
    run(0, 0, 2, $urandom_range(1, 200), 0);
    run(1, 0, $urandom_range(0, 9), $urandom_range(1, 19), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
